s_axi_write: RTL and testbench
==============================

Name: s_axi_write

Overview:
- AXI4-Lite write-channel responder for the DFX sequencer register file; the write-side counterpart of the sequencer's AXI-Lite read responder.
- Accepts AW/W beats in either order, decodes the address into bank0 (control) or bank1 (per-slot descriptor) writes, and drives the bank write interfaces.
- Returns BRESP on the B channel after the write is performed or rejected.

Parameters:
- ADDR_WIDTH, 16, AXI address width (decode uses bits [15:2])
- DATA_WIDTH, 32, AXI data width
- BANK1_INDEX_WIDTH, 2, slot index width (4 slots)
- BANK1_SIZE_WIDTH, 26, width of src/des size fields
- BANK1_STATUS_WIDTH, 2, width of the slot status field
- BANK0_CONTROL_WIDTH, 4, width of the bank0 control register

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- S_AXI_AWADDR  in  ADDR_WIDTH  write address
- S_AXI_AWVALID  in  1  address valid
- S_AXI_AWREADY  out  1  address accepted
- S_AXI_WDATA  in  DATA_WIDTH  write data
- S_AXI_WSTRB  in  DATA_WIDTH/8  byte strobes
- S_AXI_WVALID  in  1  data valid
- S_AXI_WREADY  out  1  data accepted
- S_AXI_BRESP  out  2  00 OKAY, 10 SLVERR
- S_AXI_BVALID  out  1  response valid
- S_AXI_BREADY  in  1  response accepted
- ext_bank1_in_index  out  BANK1_INDEX_WIDTH  target slot = awaddr[7:6]
- ext_bank1_in_sel  out  3  field: 0 src_addr, 1 src_size, 2 des_addr, 3 des_size, 4 status
- ext_bank1_in_data  out  32  write data; bank takes the low field-width bits
- ext_bank1_in_req  out  1  write request, held until ready
- ext_bank1_in_ready  in  1  bank1 has committed the write
- ext_bank0_in_control  out  BANK0_CONTROL_WIDTH  control value = wdata[3:0]
- ext_bank0_in_control_valid  out  1  one-cycle write strobe
- ext_bank0_out_busy  in  1  sequencer is running; bank1 is write-locked

Behaviour:
- Reset (asynchronous, active-high): state=IDLE; AWREADY=0, WREADY=0, BVALID=0, BRESP=00, ext_bank1_in_req=0, ext_bank0_in_control_valid=0; captured addr/data/strb=0.
- States:
  - IDLE: both valid → capture both, go to EXEC. AWVALID only → capture address, go to WAIT_W. WVALID only → capture data/strb, go to WAIT_AW.
  - WAIT_W: on WVALID → capture data/strb, go to EXEC.
  - WAIT_AW: on AWVALID → capture address, go to EXEC.
  - EXEC: decode and issue.
  - RESP: BVALID=1; on BREADY → IDLE.
- Ready signals (combinational from state and valid):
  - AWREADY = AWVALID && state in {IDLE, WAIT_AW}.
  - WREADY = WVALID && state in {IDLE, WAIT_W}.
  - No new AW/W is accepted in EXEC or RESP; one outstanding transaction only.
- EXEC decode, on captured address A and strobes S:
  - Error: S != all-ones → SLVERR, no write.
  - Error: A[15:14] ∉ {00, 01} → SLVERR, no write.
  - Bank0: A[15:14]=00 and A[13:6]=01 → control_valid=1 for exactly this cycle, control=wdata[3:0], BRESP=OKAY, → RESP next cycle.
  - Bank0: A[15:14]=00, any other A[13:6] (status/counters are read-only) → SLVERR, → RESP.
  - Bank1: A[15:14]=01 and A[5:2] ≤ 4 and busy=0 → req=1, sel=A[4:2], index=A[7:6], data=wdata. Stay in EXEC with req held and all outputs stable until ready=1 (ready may arrive in the first EXEC cycle); then BRESP=OKAY, → RESP next cycle, req=0 from that cycle on.
  - Bank1: A[5:2] ≥ 5 (profile and unmapped fields) → SLVERR, no req.
  - Bank1: busy=1 sampled in the first EXEC cycle → SLVERR, no req. Once req is issued, busy is ignored.
- Latency: AW+W in cycle T → EXEC at T+1 (bank0 strobe at T+1) → BVALID at T+2 when ready is immediate. Each cycle of ready delay adds one cycle.
- BRESP is registered and stable while BVALID=1.
- ext_bank1_in_index/sel/data are driven from captured registers in all states; req is asserted in EXEC only.
- Reset during EXEC or RESP: the transaction is dropped, req deasserts immediately, and no B response is sent.
- Illegal state encodings recover to IDLE.

Test Plan:
- AW=0x0040 and W=0x5 with WSTRB=F in the same cycle, ready n/a → control_valid pulse at T+1 with control=5; BVALID at T+2 with BRESP=00; after BREADY, state=IDLE.
- W=0x1000 first, AW=0x4088 three cycles later, ready delayed 4 cycles → req held 4 cycles with index=2, sel=2, data=0x1000; BRESP=00.
- AW=0x4014 (profile field) → no req asserted, BRESP=10; AW=0x4000 with WSTRB=3 → no write, BRESP=10.
- busy=1 with AW=0x4004 → no req asserted, BRESP=10; repeat with busy=0 → req with sel=1, BRESP=00.
- BREADY held low 5 cycles while AWVALID and WVALID are high → AWREADY=WREADY=0 throughout; BVALID/BRESP stable; next transaction is accepted in the cycle after BREADY.
- Reset asserted mid-EXEC with req=1 → req=0 and BVALID=0 immediately; a fresh write after reset completes normally.

Source files
------------

// File: rtl/s_axi_write_if.sv
// AXI4-Lite write-channel bundle (AW, W, B) between a register-file master and
// the s_axi_write responder.
interface s_axi_write_if #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR;
   logic                    S_AXI_AWVALID;
   logic                    S_AXI_AWREADY;
   logic [DATA_WIDTH-1:0]   S_AXI_WDATA;
   logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB;
   logic                    S_AXI_WVALID;
   logic                    S_AXI_WREADY;
   logic [1:0]              S_AXI_BRESP;
   logic                    S_AXI_BVALID;
   logic                    S_AXI_BREADY;

   modport master (
      output S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID, S_AXI_BREADY,
      input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID
   );

   modport slave (
      input  S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID, S_AXI_BREADY,
      output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID
   );
endinterface

// File: rtl/s_axi_write.sv
// AXI4-Lite write responder for the DFX sequencer register file: captures AW/W in
// either order, writes bank0 control or a bank1 slot field, then returns BRESP.
module s_axi_write #(
   parameter int ADDR_WIDTH          = 16,
   parameter int DATA_WIDTH          = 32,
   parameter int BANK1_INDEX_WIDTH   = 2,
   parameter int BANK1_SIZE_WIDTH    = 26,
   parameter int BANK1_STATUS_WIDTH  = 2,
   parameter int BANK0_CONTROL_WIDTH = 4
) (
   input  logic                           clk,
   input  logic                           reset,
   s_axi_write_if.slave                   s_axi,
   output logic [BANK1_INDEX_WIDTH-1:0]   ext_bank1_in_index,
   output logic [2:0]                     ext_bank1_in_sel,
   output logic [31:0]                    ext_bank1_in_data,
   output logic                           ext_bank1_in_req,
   input  logic                           ext_bank1_in_ready,
   output logic [BANK0_CONTROL_WIDTH-1:0] ext_bank0_in_control,
   output logic                           ext_bank0_in_control_valid,
   input  logic                           ext_bank0_out_busy
);
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WAIT_W  = 3'd1,
      WAIT_AW = 3'd2,
      EXEC    = 3'd3,
      RESP    = 3'd4
   } state_t;

   // Bank1 keeps only the low field-width bits of the 32-bit data word.
   if (BANK1_SIZE_WIDTH > 32 || BANK1_STATUS_WIDTH > 32) begin : g_bad_field_width
      $error("bank1 field wider than the 32-bit data path");
   end

   state_t                  r_state;
   logic [ADDR_WIDTH-1:0]   r_awaddr;
   logic [DATA_WIDTH-1:0]   r_wdata;
   logic [DATA_WIDTH/8-1:0] r_wstrb;
   logic                    r_bvalid;
   logic [1:0]              r_bresp;
   logic                    r_issued;

   logic w_aw_hs, w_w_hs;
   logic w_strb_ok, w_ctrl_hit, w_bank1_ok, w_bank1_go, w_unused;

   assign w_aw_hs = !reset && s_axi.S_AXI_AWVALID && (r_state == IDLE || r_state == WAIT_AW);
   assign w_w_hs  = !reset && s_axi.S_AXI_WVALID  && (r_state == IDLE || r_state == WAIT_W);

   assign s_axi.S_AXI_AWREADY = w_aw_hs;
   assign s_axi.S_AXI_WREADY  = w_w_hs;
   assign s_axi.S_AXI_BVALID  = r_bvalid;
   assign s_axi.S_AXI_BRESP   = r_bresp;

   assign w_strb_ok  = &r_wstrb;
   assign w_ctrl_hit = w_strb_ok && r_awaddr[15:14] == 2'b00 && r_awaddr[13:6] == 8'h01;
   assign w_bank1_ok = w_strb_ok && r_awaddr[15:14] == 2'b01 && r_awaddr[5:2] <= 4'd4;
   // Busy only vetoes the first EXEC cycle; an issued request rides it out.
   assign w_bank1_go = w_bank1_ok && (r_issued || !ext_bank0_out_busy);

   assign ext_bank1_in_req           = (r_state == EXEC) && w_bank1_go;
   assign ext_bank0_in_control_valid = (r_state == EXEC) && w_ctrl_hit;
   assign ext_bank1_in_index         = r_awaddr[6 +: BANK1_INDEX_WIDTH];
   assign ext_bank1_in_sel           = r_awaddr[4:2];
   assign ext_bank1_in_data          = r_wdata[31:0];
   assign ext_bank0_in_control       = r_wdata[BANK0_CONTROL_WIDTH-1:0];

   assign w_unused = &{1'b0, r_awaddr[1:0]};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= IDLE;
         r_awaddr <= '0;
         r_wdata  <= '0;
         r_wstrb  <= '0;
         r_bvalid <= 1'b0;
         r_bresp  <= RESP_OKAY;
         r_issued <= 1'b0;
      end else begin
         // NOTE: non-blocking throughout so every branch sees pre-edge state.
         if (w_aw_hs) r_awaddr <= s_axi.S_AXI_AWADDR;
         if (w_w_hs) begin
            r_wdata <= s_axi.S_AXI_WDATA;
            r_wstrb <= s_axi.S_AXI_WSTRB;
         end
         case (r_state)
            IDLE: begin
               if (w_aw_hs && w_w_hs) r_state <= EXEC;
               else if (w_aw_hs)      r_state <= WAIT_W;
               else if (w_w_hs)       r_state <= WAIT_AW;
            end
            WAIT_W:  if (w_w_hs)  r_state <= EXEC;
            WAIT_AW: if (w_aw_hs) r_state <= EXEC;
            EXEC: begin
               if (ext_bank1_in_req) begin
                  if (ext_bank1_in_ready) begin
                     r_bresp  <= RESP_OKAY;
                     r_bvalid <= 1'b1;
                     r_issued <= 1'b0;
                     r_state  <= RESP;
                  end else begin
                     r_issued <= 1'b1;
                  end
               end else begin
                  r_bresp  <= w_ctrl_hit ? RESP_OKAY : RESP_SLVERR;
                  r_bvalid <= 1'b1;
                  r_issued <= 1'b0;
                  r_state  <= RESP;
               end
            end
            RESP: begin
               if (s_axi.S_AXI_BREADY) begin
                  r_bvalid <= 1'b0;
                  r_state  <= IDLE;
               end
            end
            default: begin
               r_bvalid <= 1'b0;
               r_issued <= 1'b0;
               r_state  <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_s_axi_write.sv
// Self-checking bench for s_axi_write: directed cases plus randomized writes
// checked against a rule-level model of the register-file decode.
module tb_s_axi_write;
   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  idx;
   logic [2:0]  sel;
   logic [31:0] bdata;
   logic        req;
   logic        ready;
   logic [3:0]  ctrl;
   logic        ctrl_v;
   logic        busy;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   s_axi_write_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) axi ();

   s_axi_write dut (
      .clk                        (clk),
      .reset                      (reset),
      .s_axi                      (axi.slave),
      .ext_bank1_in_index         (idx),
      .ext_bank1_in_sel           (sel),
      .ext_bank1_in_data          (bdata),
      .ext_bank1_in_req           (req),
      .ext_bank1_in_ready         (ready),
      .ext_bank0_in_control       (ctrl),
      .ext_bank0_in_control_valid (ctrl_v),
      .ext_bank0_out_busy         (busy)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // 0 = rejected (SLVERR), 1 = bank0 control write, 2 = bank1 slot write
   function automatic int exp_kind(input logic [15:0] a, input logic [3:0] s, input logic b);
      if (s != 4'hF) return 0;
      if (a[15:14] == 2'b00) return (a[13:6] == 8'd1) ? 1 : 0;
      if (a[15:14] == 2'b01) return (int'(a[5:2]) <= 4 && !b) ? 2 : 0;
      return 0;
   endfunction

   // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
   // order: 0 AW+W together, 1 AW first, 2 W first; gap = idle cycles between them.
   task automatic write_txn(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int order, input int gap, input logic b,
                            input int rdy_dly, input int brdy_dly);
      int kind;
      logic [1:0] exp_resp;
      kind     = exp_kind(a, s, b);
      exp_resp = (kind == 0) ? 2'b10 : 2'b00;
      busy     = b;
      axi.S_AXI_AWADDR = a;
      axi.S_AXI_WDATA  = d;
      axi.S_AXI_WSTRB  = s;
      if (order == 0) begin
         axi.S_AXI_AWVALID = 1'b1;
         axi.S_AXI_WVALID  = 1'b1;
         #1;
         check("idle_bvalid", axi.S_AXI_BVALID, 1'b0);
         check("awready_both", axi.S_AXI_AWREADY, 1'b1);
         check("wready_both", axi.S_AXI_WREADY, 1'b1);
         @(negedge clk);
         axi.S_AXI_AWVALID = 1'b0;
         axi.S_AXI_WVALID  = 1'b0;
      end else begin
         if (order == 1) axi.S_AXI_AWVALID = 1'b1;
         else            axi.S_AXI_WVALID  = 1'b1;
         #1;
         check("idle_bvalid", axi.S_AXI_BVALID, 1'b0);
         check("first_ready", (order == 1) ? axi.S_AXI_AWREADY : axi.S_AXI_WREADY, 1'b1);
         @(negedge clk);
         axi.S_AXI_AWVALID = 1'b0;
         axi.S_AXI_WVALID  = 1'b0;
         for (int g = 0; g < gap; g++) begin
            #1;
            check("wait_req", req, 1'b0);
            check("wait_bvalid", axi.S_AXI_BVALID, 1'b0);
            @(negedge clk);
         end
         if (order == 1) axi.S_AXI_WVALID  = 1'b1;
         else            axi.S_AXI_AWVALID = 1'b1;
         #1;
         check("second_ready", (order == 1) ? axi.S_AXI_WREADY : axi.S_AXI_AWREADY, 1'b1);
         @(negedge clk);
         axi.S_AXI_AWVALID = 1'b0;
         axi.S_AXI_WVALID  = 1'b0;
      end

      if (kind == 2) begin
         for (int k = 0; k <= rdy_dly; k++) begin
            ready = (k == rdy_dly);
            #1;
            check("b1_req", req, 1'b1);
            check("b1_index", idx, a[7:6]);
            check("b1_sel", sel, a[4:2]);
            check("b1_data", bdata, d);
            check("b1_no_ctrl", ctrl_v, 1'b0);
            check("b1_no_bvalid", axi.S_AXI_BVALID, 1'b0);
            @(negedge clk);
            if (k == 0) busy = 1'($urandom_range(0, 1));
         end
         ready = 1'b0;
      end else begin
         #1;
         check("exec_ctrl_v", ctrl_v, kind == 1);
         if (kind == 1) check("exec_ctrl", ctrl, d[3:0]);
         check("exec_no_req", req, 1'b0);
         check("exec_no_bvalid", axi.S_AXI_BVALID, 1'b0);
         @(negedge clk);
      end

      for (int j = 0; j <= brdy_dly; j++) begin
         axi.S_AXI_AWVALID = (j < brdy_dly);
         axi.S_AXI_WVALID  = (j < brdy_dly);
         axi.S_AXI_BREADY  = (j == brdy_dly);
         #1;
         check("resp_bvalid", axi.S_AXI_BVALID, 1'b1);
         check("resp_bresp", axi.S_AXI_BRESP, exp_resp);
         check("resp_awready", axi.S_AXI_AWREADY, 1'b0);
         check("resp_wready", axi.S_AXI_WREADY, 1'b0);
         check("resp_no_req", req, 1'b0);
         check("resp_no_ctrl", ctrl_v, 1'b0);
         @(negedge clk);
      end
      axi.S_AXI_AWVALID = 1'b0;
      axi.S_AXI_WVALID  = 1'b0;
      axi.S_AXI_BREADY  = 1'b0;
      busy = 1'b0;
   endtask

   initial begin
      logic [15:0] a;
      logic [3:0]  s;
      reset = 1'b1;
      ready = 1'b0;
      busy  = 1'b0;
      axi.S_AXI_AWADDR  = '0;
      axi.S_AXI_AWVALID = 1'b1;
      axi.S_AXI_WDATA   = '0;
      axi.S_AXI_WSTRB   = '0;
      axi.S_AXI_WVALID  = 1'b1;
      axi.S_AXI_BREADY  = 1'b0;
      @(negedge clk);
      #1;
      check("rst_awready", axi.S_AXI_AWREADY, 1'b0);
      check("rst_wready", axi.S_AXI_WREADY, 1'b0);
      check("rst_bvalid", axi.S_AXI_BVALID, 1'b0);
      check("rst_bresp", axi.S_AXI_BRESP, 2'b00);
      check("rst_req", req, 1'b0);
      check("rst_ctrl_v", ctrl_v, 1'b0);
      check("rst_index", idx, 2'd0);
      check("rst_sel", sel, 3'd0);
      check("rst_data", bdata, 32'd0);
      axi.S_AXI_AWVALID = 1'b0;
      axi.S_AXI_WVALID  = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      write_txn(16'h0040, 32'h0000_0005, 4'hF, 0, 0, 1'b0, 0, 0);
      write_txn(16'h4088, 32'h0000_1000, 4'hF, 2, 3, 1'b0, 4, 0);
      write_txn(16'h4014, 32'h0000_0001, 4'hF, 0, 0, 1'b0, 0, 1);
      write_txn(16'h4000, 32'h0000_0002, 4'h3, 0, 0, 1'b0, 0, 0);
      write_txn(16'h4004, 32'h0000_0003, 4'hF, 0, 0, 1'b1, 0, 0);
      write_txn(16'h4004, 32'h0000_0003, 4'hF, 1, 1, 1'b0, 2, 0);
      write_txn(16'h0080, 32'h0000_0007, 4'hF, 0, 0, 1'b0, 0, 0);
      write_txn(16'h8040, 32'h0000_0007, 4'hF, 0, 0, 1'b0, 0, 0);
      write_txn(16'h0040, 32'h0000_0009, 4'hF, 1, 2, 1'b0, 0, 5);
      write_txn(16'h0040, 32'h0000_000A, 4'hF, 0, 0, 1'b0, 0, 0);

      // Reset while a bank1 request is outstanding.
      axi.S_AXI_AWADDR  = 16'h4044;
      axi.S_AXI_WDATA   = 32'hDEAD_BEEF;
      axi.S_AXI_WSTRB   = 4'hF;
      axi.S_AXI_AWVALID = 1'b1;
      axi.S_AXI_WVALID  = 1'b1;
      @(negedge clk);
      axi.S_AXI_AWVALID = 1'b0;
      axi.S_AXI_WVALID  = 1'b0;
      #1;
      check("mid_req", req, 1'b1);
      reset = 1'b1;
      #1;
      check("mid_rst_req", req, 1'b0);
      check("mid_rst_bvalid", axi.S_AXI_BVALID, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("post_rst_bvalid", axi.S_AXI_BVALID, 1'b0);
         check("post_rst_req", req, 1'b0);
         @(negedge clk);
      end
      write_txn(16'h40C0, 32'h0000_ABCD, 4'hF, 0, 0, 1'b0, 1, 0);

      for (int n = 0; n < 300; n++) begin
         a = 16'($urandom);
         case ($urandom_range(0, 3))
            0: begin a[15:14] = 2'b00; a[13:6] = 8'd1; end
            1: begin a[15:14] = 2'b01; a[5:2] = 4'($urandom_range(0, 6)); end
            2: a[15:14] = 2'b01;
            default: ;
         endcase
         s = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'hF;
         write_txn(a, $urandom, s, $urandom_range(0, 2), $urandom_range(0, 3),
                   1'($urandom_range(0, 3) == 0), $urandom_range(0, 4), $urandom_range(0, 3));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
